// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for the pixel SRAM arbiter: video fetch and host port.
interface sram_arbiter_if #(
  parameter int AW = 18,
  parameter int DW = 16
);
  // Video fetch engine
  logic          v_req;
  logic [AW-1:0] v_addr;
  logic [DW-1:0] v_rdata;
  logic          v_valid;

  // Host (loader / CPU) port
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic [1:0]    h_be;
  logic          h_ack;
  logic [DW-1:0] h_rdata;
  logic          h_preempt;

  modport master (
    output v_req, v_addr, h_req, h_we, h_addr, h_wdata, h_be,
    input  v_rdata, v_valid, h_ack, h_rdata, h_preempt
  );

  modport slave (
    input  v_req, v_addr, h_req, h_we, h_addr, h_wdata, h_be,
    output v_rdata, v_valid, h_ack, h_rdata, h_preempt
  );
endinterface

// File: rtl/sram_arbiter.sv
// Pixel SRAM arbiter: video reads own any cycle they request, the host FSM
// fills the gaps. Every SRAM pin comes straight from a flop.
module sram_arbiter #(
  parameter int AW        = 18,
  parameter int DW        = 16,
  parameter int WR_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus,
  output logic [AW-1:0] sram_addr,
  inout  wire  [DW-1:0] sram_dq,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          sram_lb_n,
  output logic          sram_ub_n
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WS   = 3'd2,
    WP   = 3'd3,
    WH   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int             CW      = 3;
  localparam logic [CW-1:0]  WR_LAST = CW'(WR_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;

  logic [AW-1:0] addr_q, addr_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          lb_n_q, lb_n_d;
  logic          ub_n_q, ub_n_d;
  logic          dq_oe_q, dq_oe_d;
  logic [DW-1:0] dq_out_q, dq_out_d;

  logic          vid_q, vid_d;        // the SRAM cycle now on the pins is a video read
  logic          v_valid_q, v_valid_d;
  logic [DW-1:0] v_rdata_q, v_rdata_d;
  logic [DW-1:0] h_rdata_q, h_rdata_d;
  logic          h_ack_q, h_ack_d;
  logic          h_preempt_q, h_preempt_d;

  // Host FSM: a write that has not reached its hold cycle yields to video and
  // restarts from setup; an issued read or a finished write always completes.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    h_ack_d     = 1'b0;
    h_preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.h_req && !bus.v_req) begin
          state_d = bus.h_we ? WS : RD;
        end
      end
      RD: begin
        state_d = DONE;
        h_ack_d = 1'b1;
      end
      WS: begin
        if (bus.v_req) begin
          state_d     = IDLE;
          wr_cnt_d    = '0;
          h_preempt_d = 1'b1;
        end else begin
          state_d  = WP;
          wr_cnt_d = '0;
        end
      end
      WP: begin
        if (bus.v_req) begin
          state_d     = IDLE;
          wr_cnt_d    = '0;
          h_preempt_d = 1'b1;
        end else if (wr_cnt_q == WR_LAST) begin
          state_d  = WH;
          wr_cnt_d = '0;
          h_ack_d  = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
      WH:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next SRAM pin values: video wins the cycle outright, otherwise the pins
  // follow the host state being entered. dq is only enabled while oe_n is high.
  always_comb begin
    addr_d   = addr_q;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    dq_out_d = dq_out_q;
    vid_d    = bus.v_req;
    if (bus.v_req) begin
      addr_d = bus.v_addr;
      ce_n_d = 1'b0;
      oe_n_d = 1'b0;
      lb_n_d = 1'b0;
      ub_n_d = 1'b0;
    end else begin
      unique case (state_d)
        RD: begin
          addr_d = bus.h_addr;
          ce_n_d = 1'b0;
          oe_n_d = 1'b0;
          lb_n_d = ~bus.h_be[0];
          ub_n_d = ~bus.h_be[1];
        end
        WS, WP: begin
          addr_d   = bus.h_addr;
          ce_n_d   = 1'b0;
          we_n_d   = (state_d != WP);
          lb_n_d   = ~bus.h_be[0];
          ub_n_d   = ~bus.h_be[1];
          dq_oe_d  = 1'b1;
          dq_out_d = bus.h_wdata;
        end
        WH: begin
          addr_d   = bus.h_addr;
          lb_n_d   = ~bus.h_be[0];
          ub_n_d   = ~bus.h_be[1];
          dq_oe_d  = 1'b1;
          dq_out_d = bus.h_wdata;
        end
        default: ;
      endcase
    end
  end

  // Read data capture at the end of the SRAM cycle that produced it.
  always_comb begin
    v_valid_d = vid_q;
    v_rdata_d = vid_q ? sram_dq : v_rdata_q;
    h_rdata_d = (state_q == RD) ? sram_dq : h_rdata_q;
  end

  // All state and pin registers; reset releases dq and deasserts every strobe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      addr_q      <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
      vid_q       <= 1'b0;
      v_valid_q   <= 1'b0;
      v_rdata_q   <= '0;
      h_rdata_q   <= '0;
      h_ack_q     <= 1'b0;
      h_preempt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      addr_q      <= addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
      vid_q       <= vid_d;
      v_valid_q   <= v_valid_d;
      v_rdata_q   <= v_rdata_d;
      h_rdata_q   <= h_rdata_d;
      h_ack_q     <= h_ack_d;
      h_preempt_q <= h_preempt_d;
    end
  end

  assign sram_addr = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_lb_n = lb_n_q;
  assign sram_ub_n = ub_n_q;
  assign sram_dq   = dq_oe_q ? dq_out_q : {DW{1'bz}};

  assign bus.v_valid   = v_valid_q;
  assign bus.v_rdata   = v_rdata_q;
  assign bus.h_ack     = h_ack_q;
  assign bus.h_rdata   = h_rdata_q;
  assign bus.h_preempt = h_preempt_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: async SRAM model, scoreboard of video and host
// traffic checked every cycle, plus directed scenarios with literal results.
module tb_sram_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int WR_CYCLES = 2;
  localparam int MEMSZ = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  logic sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  sram_arbiter #(.AW(AW), .DW(DW), .WR_CYCLES(WR_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_lb_n (sram_lb_n),
    .sram_ub_n (sram_ub_n)
  );

  pullup pu_dq (sram_dq);

  // Physical SRAM contents and the bench's idea of what they should be.
  logic [DW-1:0] mem     [0:MEMSZ-1];
  logic [DW-1:0] ref_mem [0:MEMSZ-1];

  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : {DW{1'bz}};

  // Asynchronous SRAM write: pins are stable for the whole cycle, so latch mid-cycle.
  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr][7:0]  = sram_dq[7:0];
      if (!sram_ub_n) mem[sram_addr][15:8] = sram_dq[15:8];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Video requests seen at the last two clock edges.
  logic          p1_req = 1'b0, p2_req = 1'b0;
  logic [AW-1:0] p1_addr = '0, p2_addr = '0;
  always @(posedge clk) begin
    if (rst) begin
      p1_req = 1'b0;
      p2_req = 1'b0;
    end else begin
      p2_req  = p1_req;
      p2_addr = p1_addr;
      p1_req  = bus.v_req;
      p1_addr = bus.v_addr;
    end
  end

  int   ack_cnt = 0;
  int   preempt_cnt = 0;
  int   we_low = 0;
  logic prev_ack = 1'b0;
  logic [AW-1:0] wr_addrs[$];

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (p1_req) begin
        chk("vid_ctl", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'b00100);
        chk("vid_addr", 32'(sram_addr), 32'(p1_addr));
      end
      chk("v_valid", 32'(bus.v_valid), 32'(p2_req));
      if (p2_req) chk("v_rdata", 32'(bus.v_rdata), 32'(ref_mem[p2_addr]));
      if (!sram_oe_n) begin
        chk("oe_with_we", 32'(sram_we_n), 32'd1);
        chk("oe_dq_clean", 32'(sram_dq), 32'(mem[sram_addr]));
      end
      if (!sram_we_n) we_low++;
      if (bus.h_preempt) preempt_cnt++;
      if (bus.h_ack) begin
        ack_cnt++;
        chk("ack_with_req", 32'(bus.h_req), 32'd1);
        chk("ack_single", 32'(prev_ack), 32'd0);
        if (bus.h_we) begin
          logic [DW-1:0] w;
          w = ref_mem[bus.h_addr];
          if (bus.h_be[0]) w[7:0]  = bus.h_wdata[7:0];
          if (bus.h_be[1]) w[15:8] = bus.h_wdata[15:8];
          ref_mem[bus.h_addr] = w;
          wr_addrs.push_back(bus.h_addr);
        end else begin
          chk("h_rdata", 32'(bus.h_rdata), 32'(ref_mem[bus.h_addr]));
        end
      end
      prev_ack = bus.h_ack;
    end else begin
      prev_ack = 1'b0;
    end
  end

  // One host transaction; lat = cycles from the request cycle to the ack cycle.
  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [1:0] be, output int lat, output logic [DW-1:0] rd);
    @(posedge clk); #1;
    bus.h_req = 1'b1; bus.h_we = we; bus.h_addr = a; bus.h_wdata = d; bus.h_be = be;
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.h_ack) break;
      lat++;
      if (lat > 3000) begin
        chk("host_timeout", 32'd1, 32'd0);
        break;
      end
    end
    rd = bus.h_rdata;
    $display("host %s addr=%05h wdata=%04h be=%b lat=%0d rdata=%04h",
             we ? "WR" : "RD", a, d, be, lat, rd);
    @(posedge clk); #1;
    bus.h_req = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctl"}, 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'b11111);
    chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
    chk({tag, "_v_valid"}, 32'(bus.v_valid), 32'd0);
    chk({tag, "_h_ack"}, 32'(bus.h_ack), 32'd0);
    chk({tag, "_h_preempt"}, 32'(bus.h_preempt), 32'd0);
    chk({tag, "_v_rdata"}, 32'(bus.v_rdata), 32'd0);
    chk({tag, "_h_rdata"}, 32'(bus.h_rdata), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic stop = 1'b0;

  initial begin
    int lat, ops, ack0, pre0;
    logic [DW-1:0] rd;
    for (int i = 0; i < MEMSZ; i++) begin
      mem[i]     = DW'(i);
      ref_mem[i] = DW'(i);
    end
    bus.v_req = 1'b0; bus.v_addr = '0;
    bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0; bus.h_be = 2'b00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst0");
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Video burst of 8 words
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(posedge clk); #1;
          bus.v_req = 1'b1; bus.v_addr = AW'(18'h00100 + i);
        end
        @(posedge clk); #1;
        bus.v_req = 1'b0;
      end
      begin
        @(posedge clk); @(posedge clk);
        @(negedge clk); chk("burst_no_early_valid", 32'(bus.v_valid), 32'd0);
        @(negedge clk);
        chk("burst_first_valid", 32'(bus.v_valid), 32'd1);
        chk("burst_first_data", 32'(bus.v_rdata), 32'h0100);
        repeat (7) @(negedge clk);
        chk("burst_last_data", 32'(bus.v_rdata), 32'h0107);
        @(negedge clk);
        chk("burst_end_valid", 32'(bus.v_valid), 32'd0);
      end
    join
    $display("video burst 0x00100..0x00107 done");

    // Idle host write then read
    we_low = 0;
    host_op(1'b1, 18'h3FFFF, 16'hA5C3, 2'b11, lat, rd);
    chk("wr_latency", 32'(lat), 32'd4);
    chk("wr_we_low_cycles", 32'(we_low), 32'd2);
    host_op(1'b0, 18'h3FFFF, 16'h0000, 2'b11, lat, rd);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_data", 32'(rd), 32'hA5C3);

    // Byte enables
    host_op(1'b1, 18'h00000, 16'hFFFF, 2'b01, lat, rd);
    host_op(1'b0, 18'h00000, 16'h0000, 2'b11, lat, rd);
    chk("be01_readback", 32'(rd), 32'h00FF);
    ack0 = ack_cnt;
    host_op(1'b1, 18'h00000, 16'h1234, 2'b00, lat, rd);
    chk("be00_ack_given", 32'(ack_cnt - ack0), 32'd1);
    chk("be00_latency", 32'(lat), 32'd4);
    host_op(1'b0, 18'h00000, 16'h0000, 2'b11, lat, rd);
    chk("be00_unchanged", 32'(rd), 32'h00FF);

    // Preemption during the first write-pulse cycle
    ack0 = ack_cnt;
    pre0 = preempt_cnt;
    fork
      host_op(1'b1, 18'h00400, 16'h5A5A, 2'b11, lat, rd);
      begin
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        bus.v_req = 1'b1; bus.v_addr = 18'h01234;
        @(negedge clk);
        chk("pre_in_wp", 32'(sram_we_n), 32'd0);
        @(posedge clk); #1;
        bus.v_req = 1'b0;
        @(negedge clk);
        chk("pre_pulse", 32'(bus.h_preempt), 32'd1);
        chk("pre_we_released", 32'(sram_we_n), 32'd1);
        chk("pre_dq_released", 32'(sram_dq), 32'h1234);
      end
    join
    chk("pre_latency", 32'(lat), 32'd7);
    chk("pre_ack_count", 32'(ack_cnt - ack0), 32'd1);
    chk("pre_preempt_count", 32'(preempt_cnt - pre0), 32'd1);
    host_op(1'b0, 18'h00400, 16'h0000, 2'b11, lat, rd);
    chk("pre_readback", 32'(rd), 32'h5A5A);

    // Asynchronous reset in the middle of a write pulse
    ack0 = ack_cnt;
    @(posedge clk); #1;
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 18'h00777; bus.h_wdata = 16'h1111; bus.h_be = 2'b11;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rstw_in_wp", 32'(sram_we_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("rstw");
    chk("rstw_dq_released", 32'(sram_dq != 16'h1111), 32'd1);
    bus.h_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    chk("rstw_no_ack", 32'(ack_cnt - ack0), 32'd0);
    host_op(1'b0, 18'h3FFFF, 16'h0000, 2'b11, lat, rd);
    chk("rstw_idle_rd_latency", 32'(lat), 32'd2);
    chk("rstw_rd_data", 32'(rd), 32'hA5C3);

    // Random traffic: video bursts against a stream of host operations
    ack0 = ack_cnt;
    ops = 0;
    fork
      begin
        int c = 0;
        while (c < 10000) begin
          int hi, lo;
          hi = $urandom_range(1, 12);
          lo = $urandom_range(1, 8);
          for (int k = 0; k < hi; k++) begin
            @(posedge clk); #1;
            bus.v_req = 1'b1; bus.v_addr = AW'(18'h01000 + $urandom_range(0, 4095));
          end
          for (int k = 0; k < lo; k++) begin
            @(posedge clk); #1;
            bus.v_req = 1'b0;
          end
          c += hi + lo;
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          host_op(1'($urandom_range(0, 1)), AW'(18'h20000 + $urandom_range(0, 31)),
                  DW'($urandom), 2'($urandom_range(0, 3)), lat, rd);
          ops++;
        end
      end
    join
    chk("rand_ack_count", 32'(ack_cnt - ack0), 32'(ops));

    // Memory contents at every acknowledged write address
    foreach (wr_addrs[i]) begin
      chk("final_mem", 32'(mem[wr_addrs[i]]), 32'(ref_mem[wr_addrs[i]]));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 256Kx16 asynchronous pixel SRAM between two requesters: the video fetch engine and a host port used by the loader or CPU to fill the bitmap.
- Video has absolute priority and is never stalled, because it fetches one word per clock during the visible window.
- The host is served in the gaps: during blanking, or whenever the video request is low.
- All SRAM control pins are registered; this block is the only driver of the SRAM pins.

Parameters:
- AW, 18, SRAM word address width.
- DW, 16, SRAM data width.
- WR_CYCLES, 2, number of consecutive SRAM cycles with sram_we_n low per host write (1..7).

Ports:
- clk  in  1  pixel/system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- v_req  in  1  video read request; one word per cycle while high.
- v_addr  in  AW  video word address, sampled with v_req.
- v_rdata  out  DW  video read data.
- v_valid  out  1  v_rdata valid this cycle.
- h_req  in  1  host request; held high until h_ack.
- h_we  in  1  1 = write, 0 = read; held with h_req.
- h_addr  in  AW  host word address; held with h_req.
- h_wdata  in  DW  host write data; held with h_req.
- h_be  in  2  byte enables {ub, lb}; held with h_req.
- h_ack  out  1  one-cycle completion pulse.
- h_rdata  out  DW  host read data, valid with h_ack on reads.
- h_preempt  out  1  pulse when video aborts a host write in progress.
- sram_addr  out  AW  SRAM address.
- sram_dq  inout  DW  SRAM data bus.
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  SRAM controls, active-low.

Behaviour:
- Reset values: sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n = 1; sram_addr = 0; sram_dq = Z; v_valid = 0, h_ack = 0, h_preempt = 0; v_rdata = 0, h_rdata = 0; FSM = IDLE; write counter = 0.
- Per-cycle arbitration decides the SRAM cycle registered at the next edge. If v_req is high, that cycle is a video read; otherwise it belongs to the host FSM.
- Video read pipeline:
  - Cycle t: v_req = 1 with v_addr = A.
  - Cycle t+1: sram_addr = A, ce_n = 0, oe_n = 0, we_n = 1, lb_n = ub_n = 0, dq = Z.
  - Cycle t+2: v_rdata = data sampled at the end of t+1; v_valid = 1.
  - Fixed latency of 2 cycles; back-to-back requests give one word per clock.
- Host FSM states:
  - IDLE: if h_req && !v_req, go to RD when !h_we, or to WS when h_we. Otherwise stay.
  - RD: SRAM drives h_addr with ce_n = 0, oe_n = 0, lb_n/ub_n = ~h_be. Next cycle: h_rdata is captured, h_ack = 1, go to DONE.
  - WS (write setup, 1 cycle): ce_n = 0, oe_n = 1, we_n = 1, dq driven with h_wdata, byte lanes from h_be.
  - WP (write pulse): as WS but we_n = 0, held for WR_CYCLES consecutive cycles.
  - WH (write hold, 1 cycle): ce_n = 1, we_n = 1, dq still driven; h_ack = 1; go to DONE.
  - DONE: 1 cycle, waits for the requester to drop or renew h_req; then IDLE. Back-to-back host ops therefore cost one dead cycle.
- Preemption:
  - v_req high while in WS or WP: abort. The video cycle is issued, dq is released on the same edge, h_preempt pulses, and the state returns to IDLE with the counter cleared.
  - The write restarts from WS once v_req drops. No h_ack is given for an aborted attempt.
  - v_req high while in WH: the video cycle is issued, dq is released, and h_ack is still given (the write has already completed).
  - An RD whose SRAM cycle was already issued always completes.
- The video cycle never waits on the host. Host write latency with v_req low is 1 + WR_CYCLES + 1 cycles to h_ack; host read latency is 2.
- Simultaneous h_req and v_req: video wins; the host waits indefinitely (no starvation guard by design, since blanking guarantees gaps).
- dq is driven only in WS, WP and WH. It is never driven in a cycle where oe_n = 0.
- h_be = 00 on a write completes normally, with no bytes written (lb_n = ub_n = 1).
- Reset mid-write forces we_n = 1 and dq = Z asynchronously. The interrupted write is lost and no ack is given.

Test Plan:
- Video burst: v_req high for 8 cycles, addresses 0x00100..0x00107, SRAM model holding addr-low-16 as data -> v_valid high for 8 cycles starting 2 cycles after v_req rises, v_rdata = 0x0100..0x0107 in order.
- Idle host write then read: h_we = 1, addr 0x3FFFF, data 0xA5C3, be = 11, v_req = 0 -> we_n low for exactly 2 cycles, h_ack 4 cycles after h_req. A following read returns h_rdata = 0xA5C3 with h_ack 2 cycles after its request.
- Preemption: host write starts; v_req rises during the first WP cycle -> h_preempt pulses, we_n returns to 1, dq goes Z on the same edge. The video read completes; the write restarts when v_req falls; memory ends with the correct value and exactly 1 h_ack.
- Contention check: random v_req / h_req traffic over 10k cycles -> no cycle with dq driven while oe_n = 0; no video latency other than 2.
- Byte enables: write 0xFFFF with be = 01 over 0x0000 -> readback 0x00FF. Write with be = 00 -> memory unchanged, h_ack still given.
- Async reset during WP -> we_n = 1 and dq = Z before the next clock edge; all outputs at reset values; FSM in IDLE.
